// File: rtl/pc_gen_if.sv
// Fetch-stage PC generator bundle: pipeline control and targets in, fetch PC and status out.
// When PC_ALIGN_CHECK_EN is defined the bundle also carries the adel_f fault pulse.
interface pc_gen_if #(
    parameter int WIDTH     = 32,
    parameter int CNT_WIDTH = 32
);
    logic                 stall;
    logic [2:0]           pc_sel;
    logic [31:0]          ir_d;
    logic [WIDTH-1:0]     pc4_d;
    logic [WIDTH-1:0]     rs_d;
    logic                 exc_req;
    logic                 eret_req;
    logic [WIDTH-1:0]     epc;
    logic [WIDTH-1:0]     pc_f;
    logic [WIDTH-1:0]     pc4_f;
    logic                 redir_pend;
    logic [CNT_WIDTH-1:0] redir_cnt;
`ifdef PC_ALIGN_CHECK_EN
    logic                 adel_f;
`endif

    modport master (
        output stall, pc_sel, ir_d, pc4_d, rs_d, exc_req, eret_req, epc,
        input  pc_f, pc4_f, redir_pend, redir_cnt
`ifdef PC_ALIGN_CHECK_EN
        , input adel_f
`endif
    );

    modport slave (
        input  stall, pc_sel, ir_d, pc4_d, rs_d, exc_req, eret_req, epc,
        output pc_f, pc4_f, redir_pend, redir_cnt
`ifdef PC_ALIGN_CHECK_EN
        , output adel_f
`endif
    );
endinterface

// File: rtl/pc_gen.sv
// Fetch-stage program counter: next-PC selection, stall hold with one buffered redirect,
// saturating redirect counter. PC_ALIGN_CHECK_EN turns misaligned redirects into an adel_f fault.
module pc_gen #(
    parameter int          WIDTH        = 32,
    parameter logic [31:0] RESET_VECTOR = 32'h0000_3000,
    parameter logic [31:0] EXC_VECTOR   = 32'h0000_4180,
    parameter int          CNT_WIDTH    = 32
) (
    input  logic     clk,
    input  logic     reset,
    pc_gen_if.slave  bus
);
    typedef enum logic {RUN, HOLD} state_t;

    localparam logic [WIDTH-1:0] RESET_PC = WIDTH'(RESET_VECTOR);
    localparam logic [WIDTH-1:0] EXC_PC   = WIDTH'(EXC_VECTOR);

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     pc_f_q, pc_f_d;
    logic [WIDTH-1:0]     pend_tgt_q, pend_tgt_d;
    logic [CNT_WIDTH-1:0] redir_cnt_q, redir_cnt_d;
    logic                 adel_f_q, adel_f_d;

    logic [WIDTH-1:0] pc_d;
    logic [WIDTH-1:0] brt, jt, tgt, app_tgt;
    logic             is_redir, apply;
    logic             unused_bits;

    assign pc_d = bus.pc4_d - WIDTH'(4);
    assign brt  = bus.pc4_d + {{(WIDTH-18){bus.ir_d[15]}}, bus.ir_d[15:0], 2'b00};
    assign jt   = {pc_d[WIDTH-1:28], bus.ir_d[25:0], 2'b00};
    assign unused_bits = ^{bus.ir_d[31:26], pc_d[27:0]};

    always_comb begin
        tgt      = brt;
        is_redir = 1'b1;
        case (bus.pc_sel)
            3'd1:    tgt = brt;
            3'd2:    tgt = jt;
            3'd3:    tgt = bus.rs_d;
            default: is_redir = 1'b0;
        endcase
    end

    // Exceptions and erets override stall and discard any buffered redirect.
    always_comb begin
        state_d     = state_q;
        pc_f_d      = pc_f_q;
        pend_tgt_d  = pend_tgt_q;
        redir_cnt_d = redir_cnt_q;
        adel_f_d    = 1'b0;
        apply       = 1'b0;
        app_tgt     = (state_q == HOLD) ? pend_tgt_q : tgt;

        if (bus.exc_req) begin
            pc_f_d  = EXC_PC;
            state_d = RUN;
        end else if (bus.eret_req) begin
            pc_f_d  = bus.epc;
            state_d = RUN;
        end else if (bus.stall) begin
            if (state_q == RUN && is_redir) begin
                pend_tgt_d = tgt;
                state_d    = HOLD;
            end
        end else if (state_q == HOLD) begin
            apply   = 1'b1;
            state_d = RUN;
        end else if (is_redir) begin
            apply = 1'b1;
        end else begin
            pc_f_d = pc_f_q + WIDTH'(4);
        end

        if (apply) begin
`ifdef PC_ALIGN_CHECK_EN
            if (app_tgt[1:0] != 2'b00) begin
                pc_f_d   = EXC_PC;
                adel_f_d = 1'b1;
            end else begin
                pc_f_d = app_tgt;
                if (redir_cnt_q != '1) redir_cnt_d = redir_cnt_q + CNT_WIDTH'(1);
            end
`else
            pc_f_d = {app_tgt[WIDTH-1:2], 2'b00};
            if (redir_cnt_q != '1) redir_cnt_d = redir_cnt_q + CNT_WIDTH'(1);
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= RUN;
            pc_f_q      <= RESET_PC;
            pend_tgt_q  <= '0;
            redir_cnt_q <= '0;
            adel_f_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_f_q      <= pc_f_d;
            pend_tgt_q  <= pend_tgt_d;
            redir_cnt_q <= redir_cnt_d;
            adel_f_q    <= adel_f_d;
        end
    end

    assign bus.pc_f       = pc_f_q;
    assign bus.pc4_f      = pc_f_q + WIDTH'(4);
    assign bus.redir_pend = (state_q == HOLD);
    assign bus.redir_cnt  = redir_cnt_q;
`ifdef PC_ALIGN_CHECK_EN
    assign bus.adel_f     = adel_f_q;
`else
    logic unused_adel;
    assign unused_adel = adel_f_q ^ unused_bits;
`endif
`ifdef PC_ALIGN_CHECK_EN
    logic unused_chk;
    assign unused_chk = unused_bits;
`endif
endmodule

// File: tb/tb_pc_gen.sv
// Directed-vector bench for pc_gen; expectations are hand-computed for both
// the default build and the PC_ALIGN_CHECK_EN build.
module tb_pc_gen;
    logic clk = 1'b0;
    logic reset;
    int   tests_run    = 0;
    int   tests_failed = 0;

    pc_gen_if #(.WIDTH(32), .CNT_WIDTH(32)) bus ();

    pc_gen #(
        .WIDTH(32), .RESET_VECTOR(32'h0000_3000), .EXC_VECTOR(32'h0000_4180), .CNT_WIDTH(32)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.stall    = 1'b0;
        bus.pc_sel   = 3'd0;
        bus.ir_d     = 32'h0;
        bus.pc4_d    = 32'h0;
        bus.rs_d     = 32'h0;
        bus.exc_req  = 1'b0;
        bus.eret_req = 1'b0;
        bus.epc      = 32'h0;
    endtask

    task automatic test_reset();
        logic [31:0] exp_seq [3];
        exp_seq = '{32'h3004, 32'h3008, 32'h300C};
        reset = 1'b1;
        idle_inputs();
        step();
        step();
        tests_run++;
        if (bus.pc_f !== 32'h3000) begin tests_failed++; $display("[TB] FAIL reset_pc: got %h expected %h", bus.pc_f, 32'h3000); end
        tests_run++;
        if (bus.pc4_f !== 32'h3004) begin tests_failed++; $display("[TB] FAIL reset_pc4: got %h expected %h", bus.pc4_f, 32'h3004); end
        tests_run++;
        if (bus.redir_pend !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_pend: got %b expected 0", bus.redir_pend); end
        tests_run++;
        if (bus.redir_cnt !== 32'd0) begin tests_failed++; $display("[TB] FAIL reset_cnt: got %0d expected 0", bus.redir_cnt); end
`ifdef PC_ALIGN_CHECK_EN
        tests_run++;
        if (bus.adel_f !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_adel: got %b expected 0", bus.adel_f); end
`endif
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            tests_run++;
            if (bus.pc_f !== exp_seq[i]) begin tests_failed++; $display("[TB] FAIL seq_pc[%0d]: got %h expected %h", i, bus.pc_f, exp_seq[i]); end
        end
        tests_run++;
        if (bus.redir_cnt !== 32'd0) begin tests_failed++; $display("[TB] FAIL seq_cnt: got %0d expected 0", bus.redir_cnt); end
    endtask

    task automatic test_branch();
        bus.pc4_d  = 32'h3008;
        bus.ir_d   = 32'h0000_FFFE;
        bus.pc_sel = 3'd1;
        step();
        bus.pc_sel = 3'd0;
        tests_run++;
        if (bus.pc_f !== 32'h3000) begin tests_failed++; $display("[TB] FAIL branch_pc: got %h expected %h", bus.pc_f, 32'h3000); end
        tests_run++;
        if (bus.redir_cnt !== 32'd1) begin tests_failed++; $display("[TB] FAIL branch_cnt: got %0d expected 1", bus.redir_cnt); end
    endtask

    task automatic test_jump();
        bus.pc4_d  = 32'h3010;
        bus.ir_d   = 32'h0000_0C40;
        bus.pc_sel = 3'd2;
        step();
        tests_run++;
        if (bus.pc_f !== 32'h3100) begin tests_failed++; $display("[TB] FAIL j_pc: got %h expected %h", bus.pc_f, 32'h3100); end
        tests_run++;
        if (bus.redir_cnt !== 32'd2) begin tests_failed++; $display("[TB] FAIL j_cnt: got %0d expected 2", bus.redir_cnt); end
        bus.rs_d   = 32'h3200;
        bus.pc_sel = 3'd3;
        step();
        bus.pc_sel = 3'd0;
        tests_run++;
        if (bus.pc_f !== 32'h3200) begin tests_failed++; $display("[TB] FAIL jr_pc: got %h expected %h", bus.pc_f, 32'h3200); end
        tests_run++;
        if (bus.redir_cnt !== 32'd3) begin tests_failed++; $display("[TB] FAIL jr_cnt: got %0d expected 3", bus.redir_cnt); end
    endtask

    task automatic test_stall_hold();
        bus.stall  = 1'b1;
        bus.pc_sel = 3'd3;
        bus.rs_d   = 32'h5000;
        step();
        bus.rs_d = 32'h6000;
        for (int i = 0; i < 3; i++) begin
            tests_run++;
            if (bus.pc_f !== 32'h3200) begin tests_failed++; $display("[TB] FAIL hold_pc[%0d]: got %h expected %h", i, bus.pc_f, 32'h3200); end
            tests_run++;
            if (bus.redir_pend !== 1'b1) begin tests_failed++; $display("[TB] FAIL hold_pend[%0d]: got %b expected 1", i, bus.redir_pend); end
            if (i < 2) step();
        end
        bus.stall = 1'b0;
        step();
        bus.pc_sel = 3'd0;
        tests_run++;
        if (bus.pc_f !== 32'h5000) begin tests_failed++; $display("[TB] FAIL release_pc: got %h expected %h", bus.pc_f, 32'h5000); end
        tests_run++;
        if (bus.redir_pend !== 1'b0) begin tests_failed++; $display("[TB] FAIL release_pend: got %b expected 0", bus.redir_pend); end
        tests_run++;
        if (bus.redir_cnt !== 32'd4) begin tests_failed++; $display("[TB] FAIL release_cnt: got %0d expected 4", bus.redir_cnt); end
    endtask

    task automatic test_exc_eret();
        bus.stall  = 1'b1;
        bus.pc_sel = 3'd3;
        bus.rs_d   = 32'h7000;
        step();
        tests_run++;
        if (bus.redir_pend !== 1'b1) begin tests_failed++; $display("[TB] FAIL exc_setup_pend: got %b expected 1", bus.redir_pend); end
        bus.exc_req  = 1'b1;
        bus.eret_req = 1'b1;
        bus.epc      = 32'h3024;
        step();
        tests_run++;
        if (bus.pc_f !== 32'h4180) begin tests_failed++; $display("[TB] FAIL exc_pc: got %h expected %h", bus.pc_f, 32'h4180); end
        tests_run++;
        if (bus.redir_pend !== 1'b0) begin tests_failed++; $display("[TB] FAIL exc_pend: got %b expected 0", bus.redir_pend); end
        bus.exc_req = 1'b0;
        step();
        tests_run++;
        if (bus.pc_f !== 32'h3024) begin tests_failed++; $display("[TB] FAIL eret_pc: got %h expected %h", bus.pc_f, 32'h3024); end
        bus.eret_req = 1'b0;
        bus.stall    = 1'b0;
        bus.pc_sel   = 3'd0;
        step();
        tests_run++;
        if (bus.pc_f !== 32'h3028) begin tests_failed++; $display("[TB] FAIL post_eret_pc: got %h expected %h", bus.pc_f, 32'h3028); end
        tests_run++;
        if (bus.redir_cnt !== 32'd4) begin tests_failed++; $display("[TB] FAIL exc_cnt: got %0d expected 4", bus.redir_cnt); end
    endtask

    task automatic test_align();
        bus.pc_sel = 3'd3;
        bus.rs_d   = 32'h3002;
        step();
        bus.pc_sel = 3'd0;
`ifdef PC_ALIGN_CHECK_EN
        tests_run++;
        if (bus.pc_f !== 32'h4180) begin tests_failed++; $display("[TB] FAIL adel_pc: got %h expected %h", bus.pc_f, 32'h4180); end
        tests_run++;
        if (bus.adel_f !== 1'b1) begin tests_failed++; $display("[TB] FAIL adel_pulse: got %b expected 1", bus.adel_f); end
        tests_run++;
        if (bus.redir_cnt !== 32'd4) begin tests_failed++; $display("[TB] FAIL adel_cnt: got %0d expected 4", bus.redir_cnt); end
        step();
        tests_run++;
        if (bus.adel_f !== 1'b0) begin tests_failed++; $display("[TB] FAIL adel_clear: got %b expected 0", bus.adel_f); end
        tests_run++;
        if (bus.pc_f !== 32'h4184) begin tests_failed++; $display("[TB] FAIL adel_next_pc: got %h expected %h", bus.pc_f, 32'h4184); end
`else
        tests_run++;
        if (bus.pc_f !== 32'h3000) begin tests_failed++; $display("[TB] FAIL align_pc: got %h expected %h", bus.pc_f, 32'h3000); end
        tests_run++;
        if (bus.redir_cnt !== 32'd5) begin tests_failed++; $display("[TB] FAIL align_cnt: got %0d expected 5", bus.redir_cnt); end
`endif
    endtask

    task automatic test_wrap();
        bus.pc_sel = 3'd3;
        bus.rs_d   = 32'hFFFF_FFFC;
        step();
        bus.pc_sel = 3'd0;
        tests_run++;
        if (bus.pc4_f !== 32'h0) begin tests_failed++; $display("[TB] FAIL wrap_pc4: got %h expected %h", bus.pc4_f, 32'h0); end
        step();
        tests_run++;
        if (bus.pc_f !== 32'h0) begin tests_failed++; $display("[TB] FAIL wrap_pc: got %h expected %h", bus.pc_f, 32'h0); end
    endtask

    task automatic test_reset_mid_hold();
        bus.stall  = 1'b1;
        bus.pc_sel = 3'd3;
        bus.rs_d   = 32'h8000;
        step();
        reset = 1'b1;
        step();
        reset      = 1'b0;
        bus.stall  = 1'b0;
        bus.pc_sel = 3'd0;
        tests_run++;
        if (bus.redir_pend !== 1'b0) begin tests_failed++; $display("[TB] FAIL rst_hold_pend: got %b expected 0", bus.redir_pend); end
        tests_run++;
        if (bus.redir_cnt !== 32'd0) begin tests_failed++; $display("[TB] FAIL rst_hold_cnt: got %0d expected 0", bus.redir_cnt); end
        step();
        tests_run++;
        if (bus.pc_f !== 32'h3004) begin tests_failed++; $display("[TB] FAIL rst_hold_pc: got %h expected %h", bus.pc_f, 32'h3004); end
    endtask

    initial begin
        test_reset();
        test_branch();
        test_jump();
        test_stall_hold();
        test_exc_eret();
        test_align();
        test_wrap();
        test_reset_mid_hold();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
